port_arbiter: RTL and testbench

- Single-output round-robin arbiter with a one-entry output register for the router mesh.
- Shares one output link (east, west, local or vertical) between up to `N_IN` input-side routing units. Those units emit 16-bit single-flit packets with the dx field in [15:12], already updated for the hop.
- Selects one requesting input per cycle, registers the winning packet and presents it downstream under a valid/ready handshake.
- Sits between the per-input routing stages and each physical output port, one instance per output.

---
 rtl/port_arbiter.sv | 107 ++++++++++
 tb/tb_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin N_IN:1 arbiter feeding a one-entry registered output stage.
// Defining ARB_PKT_CNT_EN adds a saturating accepted-packet counter on pkt_count.
module port_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        req_valid,
  input  logic [N_IN*DATA_W-1:0] req_packet,
  output logic [N_IN-1:0]        req_ready,
  output logic [DATA_W-1:0]      out_packet,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [15:0]            pkt_count
`endif
);
  localparam int PW = $clog2(N_IN);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] pkt_p0;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [N_IN-1:0]   grant;
  logic [PW-1:0]     gidx;
  logic              load_ok, take, drain;
  int                j;

  assign load_ok = (state_p0 == EMPTY) || out_ready;

  // Circular priority search from ptr; the lowest offset wins because it is assigned last.
  always_comb begin
    grant = '0;
    gidx  = '0;
    j     = 0;
    if (load_ok && rst_n) begin
      for (int k = N_IN - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= N_IN) j = j - N_IN;
        if (req_valid[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          gidx     = PW'(j);
        end
      end
    end
  end

  assign req_ready = grant;
  assign take      = |grant;
  assign drain     = (state_p0 == FULL) && out_ready;

  always_comb begin
    state_nxt = state_p0;
    ptr_nxt   = ptr;
    if (take) begin
      state_nxt = FULL;
      ptr_nxt   = (gidx == PW'(N_IN - 1)) ? '0 : gidx + PW'(1);
    end else if (drain) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= EMPTY;
      ptr      <= '0;
    end else begin
      state_p0 <= state_nxt;
      ptr      <= ptr_nxt;
    end
  end

  // Output stage p0: packet is captured only on a grant, so a drain leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_p0 <= '0;
    end else if (take) begin
      pkt_p0 <= req_packet[gidx*DATA_W +: DATA_W];
    end
  end

  assign out_packet = pkt_p0;
  assign out_valid  = state_p0;

`ifdef ARB_PKT_CNT_EN
  logic [15:0] cnt_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (drain) begin
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign pkt_count = cnt_p0;
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: scoreboard bench for port_arbiter (4 inputs, 16-bit packets).
// Granted packets are queued from an independent grant model and popped on output transfers.
module tb_port_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   rv;
  logic [W-1:0]   pk [N];
  logic [N*W-1:0] req_packet;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_packet;
  logic           out_valid;
  logic           out_ready;
`ifdef ARB_PKT_CNT_EN
  logic [15:0]    pkt_count;
`endif

  port_arbiter #(.N_IN(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (rv),
    .req_packet (req_packet),
    .req_ready  (req_ready),
    .out_packet (out_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef ARB_PKT_CNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_packet = '0;
    for (int i = 0; i < N; i++) req_packet[i*W +: W] = pk[i];
  end

  int          total = 0;
  int          bad = 0;
  int          m_ptr = 0;
  bit          m_full = 1'b0;
  bit          refill = 1'b0;
  int          m_cnt = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p, input bit lok);
    logic [N-1:0] g;
    g = '0;
    if (!lok) return g;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) begin
        g[(p + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // One clock: check at the falling edge, update the model, advance past the rising edge.
  task automatic cycle();
    logic [N-1:0] mg;
    bit xfer;
    @(negedge clk);
    mg = model_grant(rv, m_ptr, !m_full || out_ready);
    chk("grant", 32'(req_ready), 32'(mg));
    chk("vld", 32'(out_valid), 32'(m_full));
`ifdef ARB_PKT_CNT_EN
    chk("cnt", 32'(pkt_count), m_cnt);
`endif
    xfer = m_full && out_ready;
    if (m_full) begin
      chk("pkt", 32'(out_packet), 32'(exp_q[0]));
      if (out_ready) begin
        void'(exp_q.pop_front());
        m_full = 1'b0;
      end
    end
    if (xfer && m_cnt < 65535) m_cnt++;
    for (int g = 0; g < N; g++) begin
      if (mg[g]) begin
        exp_q.push_back(pk[g]);
        m_full = 1'b1;
        m_ptr  = (g == N - 1) ? 0 : g + 1;
      end
    end
    @(posedge clk);
    #1;
    if (!refill) rv = rv & ~mg;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rv = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) pk[i] = 16'(16'h0101 * (i + 1));

    // Reset: no grant even with requests present.
    #1;
    rst_n = 1'b0;
    rv = 4'b1111;
    @(negedge clk);
    chk("rst_grant", 32'(req_ready), 32'h0);
    chk("rst_vld", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rv = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("idle_pkt", 32'(out_packet), 32'h0);
    end

    // Single request on input 2.
    out_ready = 1'b1;
    rv = 4'b0100;
    pk[2] = 16'hF123;
    cycle();
    cycle();
    // ptr now 3: input 3 must beat input 0.
    rv = 4'b1001;
    pk[0] = 16'h0A00;
    pk[3] = 16'h0A03;
    cycle();
    cycle();
    cycle();

    // Round-robin with all inputs requesting continuously.
    pk[0] = 16'h1000; pk[1] = 16'h2000; pk[2] = 16'h3000; pk[3] = 16'h4000;
    rv = 4'b1111;
    refill = 1'b1;
    repeat (8) cycle();
    refill = 1'b0;
    rv = '0;
    repeat (2) cycle();

    // Backpressure while holding A5A5.
    out_ready = 1'b0;
    rv = 4'b0001;
    pk[0] = 16'hA5A5;
    cycle();
    rv = 4'b0011;
    pk[0] = 16'h0B00;
    pk[1] = 16'h0B01;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (4) cycle();

    // Asynchronous reset while FULL with 7E01.
    out_ready = 1'b0;
    rv = 4'b0010;
    pk[1] = 16'h7E01;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'h0);
    chk("mid_rst_pkt", 32'(out_packet), 32'h0);
    m_full = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    exp_q.delete();
    rv = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = 4'b1010;
    pk[1] = 16'h0C01;
    pk[3] = 16'h0C03;
    out_ready = 1'b1;
    repeat (4) cycle();

`ifdef ARB_PKT_CNT_EN
    // Saturation of the transfer counter.
    rv = 4'b1111;
    refill = 1'b1;
    repeat (65540) cycle();
    refill = 1'b0;
    rv = '0;
    repeat (3) cycle();
    chk("cnt_sat", 32'(pkt_count), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
